// File: rtl/bram_frame_writer.sv
// bram_frame_writer: write side of the frame-buffer BRAM.
// Turns an RGB565 SOF/EOL pixel stream into row-major BRAM writes.
//
// Ports:
//   CLK, RESET_N      write clock, async active-low reset
//   PIX_DATA          RGB565 pixel (R[15:11] G[10:5] B[4:0])
//   PIX_VALID/READY   beat handshake; PIX_SOF/PIX_EOL frame/line markers
//   Reverse_SW        vertical flip request, sampled on SOF
//   BRAMADDR/DIN/WE   registered write port, one word per cycle
//   FRAME_DONE        pulse after the last line is written
//   ERR_LINE          pulse on a short or overlong line
//   ERR_FRAME         pulse on SOF inside a frame
module bram_frame_writer #(
    parameter int HSIZE  = 640,
    parameter int VSIZE  = 480,
    parameter int ADDR_W = 19
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [15:0]       PIX_DATA,
    input  logic              PIX_VALID,
    output logic              PIX_READY,
    input  logic              PIX_SOF,
    input  logic              PIX_EOL,
    input  logic              Reverse_SW,
    output logic [ADDR_W-1:0] BRAMADDR,
    output logic [15:0]       BRAMDIN,
    output logic              BRAMWE,
    output logic              FRAME_DONE,
    output logic              ERR_LINE,
    output logic              ERR_FRAME
);

    localparam int HW = $clog2(HSIZE + 1);
    localparam int LW = $clog2(VSIZE + 1);

    localparam logic [ADDR_W-1:0] HSTEP    = ADDR_W'(HSIZE);
    localparam logic [ADDR_W-1:0] BASE_REV = ADDR_W'((VSIZE - 1) * HSIZE);
    localparam logic [HW-1:0]     HMAX     = HW'(HSIZE);
    localparam logic [HW-1:0]     HLAST    = HW'(HSIZE - 1);
    localparam logic [LW-1:0]     VLAST    = LW'(VSIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [HW-1:0]       hcnt_q, hcnt_d;
    logic [LW-1:0]       lcnt_q, lcnt_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                rev_q, rev_d;
    logic                long_q, long_d;

    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         din_q, din_d;
    logic                we_q, we_d;
    logic                fd_q, fd_d;
    logic                el_q, el_d;
    logic                ef_q, ef_d;

    logic                accept;
    logic                active;
    logic                sof_go;
    logic [HW-1:0]       h_e;
    logic [LW-1:0]       l_e;
    logic [ADDR_W-1:0]   b_e;
    logic                r_e;
    logic                long_e;

    // Ready drops only for the single DONE cycle, and while in reset.
    assign PIX_READY = RESET_N && (state_q != S_DONE);

    assign accept = PIX_VALID && PIX_READY;
    assign sof_go = accept && PIX_SOF;

    // A beat is processed in WRITE, or in IDLE only when it carries SOF.
    assign active = accept && (PIX_SOF || (state_q == S_WRITE));

    // SOF restarts the frame before the rest of the beat is applied,
    // so all per-beat work uses these effective values.
    assign h_e    = sof_go ? '0 : hcnt_q;
    assign l_e    = sof_go ? '0 : lcnt_q;
    assign r_e    = sof_go ? Reverse_SW : rev_q;
    assign long_e = sof_go ? 1'b0 : long_q;
    assign b_e    = sof_go ? (Reverse_SW ? BASE_REV : '0) : base_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hcnt_q <= '0;
            lcnt_q <= '0;
            base_q <= '0;
            rev_q  <= 1'b0;
            long_q <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
            we_q   <= 1'b0;
            fd_q   <= 1'b0;
            el_q   <= 1'b0;
            ef_q   <= 1'b0;
        end else begin
            hcnt_q <= hcnt_d;
            lcnt_q <= lcnt_d;
            base_q <= base_d;
            rev_q  <= rev_d;
            long_q <= long_d;
            addr_q <= addr_d;
            din_q  <= din_d;
            we_q   <= we_d;
            fd_q   <= fd_d;
            el_q   <= el_d;
            ef_q   <= ef_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        lcnt_d  = lcnt_q;
        base_d  = base_q;
        rev_d   = rev_q;
        long_d  = long_q;
        addr_d  = addr_q;
        din_d   = din_q;
        we_d    = 1'b0;
        fd_d    = 1'b0;
        el_d    = 1'b0;
        ef_d    = 1'b0;

        unique case (state_q)
            S_DONE: begin
                state_d = S_IDLE;
                hcnt_d  = '0;
                lcnt_d  = '0;
            end
            S_WRITE: begin
                ef_d = sof_go;
            end
            default: begin
            end
        endcase

        if (active) begin
            state_d = S_WRITE;
            rev_d   = r_e;
            lcnt_d  = l_e;
            base_d  = b_e;
            hcnt_d  = h_e;
            long_d  = long_e;

            if (h_e < HMAX) begin
                we_d   = 1'b1;
                addr_d = b_e + ADDR_W'(h_e);
                din_d  = PIX_DATA;
                hcnt_d = h_e + 1'b1;
                // EOL before the last column: short line.
                if (PIX_EOL && (h_e < HLAST)) begin
                    el_d = 1'b1;
                end
            end else if (!long_e) begin
                // First dropped beat of an overlong line.
                el_d   = 1'b1;
                long_d = 1'b1;
            end

            if (PIX_EOL) begin
                hcnt_d = '0;
                long_d = 1'b0;
                lcnt_d = l_e + 1'b1;
                base_d = r_e ? (b_e - HSTEP) : (b_e + HSTEP);
                if (l_e == VLAST) begin
                    state_d = S_DONE;
                    fd_d    = 1'b1;
                end
            end
        end
    end

    assign BRAMADDR   = addr_q;
    assign BRAMDIN    = din_q;
    assign BRAMWE     = we_q;
    assign FRAME_DONE = fd_q;
    assign ERR_LINE   = el_q;
    assign ERR_FRAME  = ef_q;

endmodule

// File: doc/bram_frame_writer.md
Name: bram_frame_writer

Overview:
- Write side of the frame-buffer BRAM.
- Accepts an RGB565 pixel stream with start-of-frame and end-of-line markers, and generates BRAM write addresses, data and write-enable.
- Lays one frame out row-major (line base + column); the display-side BRAM controller reads it back.
- Supports vertical flip: lines are stored bottom-up when Reverse_SW is high, sampled once per frame.

Parameters:
- HSIZE, 640, active pixels per line.
- VSIZE, 480, active lines per frame.
- ADDR_W, 19, BRAM address width; must satisfy 2^ADDR_W >= HSIZE*VSIZE.

Ports:
- CLK  input  1  pixel/BRAM write clock, rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- PIX_DATA  input  16  RGB565 pixel (R[15:11] G[10:5] B[4:0]).
- PIX_VALID  input  1  PIX_DATA/PIX_SOF/PIX_EOL valid this cycle.
- PIX_READY  output  1  beat accepted when PIX_VALID && PIX_READY.
- PIX_SOF  input  1  first pixel of frame.
- PIX_EOL  input  1  last pixel of line.
- Reverse_SW  input  1  vertical flip request.
- BRAMADDR  output  ADDR_W  write address.
- BRAMDIN  output  16  write data.
- BRAMWE  output  1  write strobe, one word per cycle.
- FRAME_DONE  output  1  one-cycle pulse after last line written.
- ERR_LINE  output  1  one-cycle pulse on short/long line.
- ERR_FRAME  output  1  one-cycle pulse on SOF mid-frame.

Behaviour:
- Reset (async assert, sync release): state IDLE; hcnt=0, lcnt=0, line_base=0, rev_q=0. Outputs: BRAMADDR=0, BRAMDIN=0, BRAMWE=0, FRAME_DONE=0, ERR_*=0, PIX_READY=0 during reset.
- Reset mid-frame: the frame is abandoned with no further writes. After release the block waits for a new SOF.
- PIX_READY: 1 in IDLE and WRITE; 0 in DONE (one cycle).
- Write latency: an accepted beat produces BRAMWE=1 on the next cycle, with registered BRAMADDR and BRAMDIN. One write per accepted beat, at most one per cycle.
- Address = line_base + hcnt, computed at ADDR_W bits. hcnt is ceil(log2(HSIZE+1)) bits.
- Frame start, line_base init: rev_q=0 gives 0; rev_q=1 gives (VSIZE-1)*HSIZE.
- Line advance, line_base step: +HSIZE when rev_q=0, -HSIZE when rev_q=1.
- IDLE:
  - Beats without SOF are accepted and dropped, no write.
  - Beat with SOF: latch rev_q=Reverse_SW, init line_base, write the pixel at hcnt=0, go to WRITE.
- WRITE, per accepted beat:
  - hcnt<HSIZE: write at line_base+hcnt, then hcnt++.
  - hcnt==HSIZE (overlong line): drop the beat with no write. Pulse ERR_LINE once per line, on the first dropped beat.
  - EOL on a beat with hcnt+1<HSIZE (short line): write the beat, pulse ERR_LINE. Unwritten columns keep old contents.
  - On EOL: hcnt=0, lcnt++, line_base steps. If lcnt was VSIZE-1, go to DONE.
- SOF in WRITE: pulse ERR_FRAME, restart as in IDLE-with-SOF. Re-sample Reverse_SW, reset lcnt and line_base, write the beat at column 0.
- SOF and EOL on the same beat: the SOF restart happens first, then the EOL is applied (one-pixel line).
- DONE: pulse FRAME_DONE, clear lcnt and hcnt, go to IDLE next cycle.
- Reverse_SW changes mid-frame are ignored until the next SOF.

Test Plan:
- Forward frame (HSIZE=4, VSIZE=3, Reverse_SW=0): 12 beats, SOF on beat 0, EOL on beats 3/7/11 -> writes to addresses 0..11 in order, each exactly one cycle after acceptance. FRAME_DONE pulses once; PIX_READY=0 for one cycle.
- Flipped frame (same, Reverse_SW=1): write addresses 8,9,10,11,4,5,6,7,0,1,2,3. Toggling Reverse_SW mid-frame changes nothing.
- Short/long lines: line 0 EOL on beat 2 -> 3 writes (0..2) and ERR_LINE; next line starts at 4. Line with 6 beats -> 4 writes, beats 5-6 dropped, one ERR_LINE.
- Pre-SOF junk and mid-frame SOF: 5 beats without SOF -> no BRAMWE. SOF at line 1 col 2 -> ERR_FRAME, write to addr 0, frame completes normally after that.
- Back-pressure/gaps: PIX_VALID toggled randomly -> write count equals accepted beats and address sequence is unchanged.
- RESET_N asserted mid-frame (asynchronously, between edges) -> outputs 0 immediately. After release, beats without SOF are dropped and the next SOF writes addr 0.
